mips_multicycle_controller: RTL

Moore-style control FSM that sequences a shared-memory, multi-cycle MIPS32 datapath. One instruction takes 3–5 cycles. The controller decodes opcode and funct, drives every datapath select and enable, flags unsupported opcodes, and counts retired instructions. It replaces the single-cycle control path when the datapath is refactored to one ALU, one memory and the IR/A/B/ALUOut holding registers.

---
 rtl/mips_mc_pkg.sv | 41 ++++
 rtl/mips_mc_decode.sv | 92 +++++++++
 rtl/mips_multicycle_controller.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS32 controller: FSM states, opcodes
// and the datapath mux select values.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11,
        StHalt     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUB_B       = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational state -> control-word lookup (Moore outputs of the controller).
module mips_mc_decode
    import mips_mc_pkg::*;
(
    input  logic [3:0] state,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        unique case (state_e'(state))
            StFetch: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = ALUB_FOUR;
            end
            StDecode: alu_src_b = ALUB_IMM_SH2;
            StMemAddr, StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            StRWb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            StJump: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS32 control FSM: state register, opcode dispatch, sticky
// illegal-opcode flag and retired-instruction counter.
module mips_multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_e              r_state;
    state_e              w_state_next;
    logic                w_to_halt;
    logic                r_illegal;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_instr_done;
    logic                w_unused_inputs;

    // funct and zero belong to the datapath (ALU control, PC load gating).
    assign w_unused_inputs = ^{funct, zero};

    always_comb begin
        w_state_next = r_state;
        w_to_halt    = 1'b0;
        unique case (r_state)
            StFetch:  w_state_next = StDecode;
            StDecode: begin
                unique case (opcode)
                    OP_RTYPE:     w_state_next = StRExec;
                    OP_LW, OP_SW: w_state_next = StMemAddr;
                    OP_BEQ:       w_state_next = StBranch;
                    OP_J:         w_state_next = StJump;
                    OP_ADDI:      w_state_next = StAddiExec;
                    default: begin
                        w_state_next = StHalt;
                        w_to_halt    = 1'b1;
                    end
                endcase
            end
            StMemAddr:  w_state_next = (opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd:    w_state_next = StMemWb;
            StRExec:    w_state_next = StRWb;
            StAddiExec: w_state_next = StAddiWb;
            StMemWb, StMemWr, StRWb, StBranch, StJump, StAddiWb: w_state_next = StFetch;
            StHalt:     w_state_next = StHalt;
            default:    w_state_next = StFetch;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= StFetch;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_to_halt) begin
                r_illegal <= 1'b1;
            end
            if (w_instr_done) begin
                r_retired <= r_retired + RETIRE_W'(1);
            end
        end
    end

    mips_mc_decode u_decode (
        .state         (r_state),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (w_instr_done)
    );

    assign state      = r_state;
    assign instr_done = w_instr_done;
    assign illegal    = r_illegal;
    assign retired    = r_retired;

endmodule
